sigmag_agc: RTL and testbench

SIGMAG_AGC -- requirements
Module: sigmag_agc

---
 rtl/sigmag_agc.sv | 198 +++++++++++++++++++
 tb/tb_sigmag_agc.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmag_agc.sv
// sigmag_agc: sign/magnitude quantiser for a raw ADC stream with a
// window-based adaptive magnitude threshold.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | loop disabled; th follows cfg_th_init, counters cleared
//   RUN    | counting valid samples and magnitude hits in the window
//   UPDATE | one cycle; window just closed, apply +/-1 threshold step
//
// The quantiser runs in every state. In IDLE (and during reset) the
// threshold output is cfg_th_init combinationally, so reset takes effect
// on th without a clock edge and the register never needs an async load
// of a non-constant value.
module sigmag_agc #(
  parameter int DW = 12,
  parameter int TW = DW - 1,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          cfg_en,
  input  logic [CW-1:0] cfg_win_len,
  input  logic [CW-1:0] cfg_target,
  input  logic [CW-1:0] cfg_hyst,
  input  logic [TW-1:0] cfg_th_init,
  output logic          out_valid,
  output logic          out_sig,
  output logic          out_mag,
  output logic [TW-1:0] th,
  output logic          win_done,
  output logic [CW-1:0] mag_cnt_last
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;

  // common width for comparing |sample| against the threshold
  localparam int MW = (TW > DW - 1) ? TW : DW - 1;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] th_reg;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] mag_cnt;

  logic [DW-2:0] neg_low;
  logic [DW-2:0] abs_val;
  logic [MW-1:0] abs_ext;
  logic [MW-1:0] th_ext;
  logic          hit;

  logic [CW-1:0] eff_len;
  logic [CW:0]   win_next;
  logic [CW-1:0] mag_next;
  logic          close;

  logic [CW:0]   upper;
  logic [CW:0]   lower;
  logic          inc_req;
  logic          dec_req;
  logic [TW-1:0] th_max;

  assign th       = (state == S_IDLE) ? cfg_th_init : th_reg;
  assign win_done = (state == S_UPD);
  assign th_max   = '1;

  // absolute value of the sample; the most negative code saturates
  always_comb begin
    neg_low = (~in_data[DW-2:0]) + {{(DW-2){1'b0}}, 1'b1};
    abs_val = in_data[DW-2:0];
    if (in_data[DW-1]) begin
      if (in_data[DW-2:0] == '0) begin
        abs_val = '1;
      end else begin
        abs_val = neg_low;
      end
    end
    abs_ext = MW'(abs_val);
    th_ext  = MW'(th);
    hit     = (abs_ext >= th_ext);
  end

  // window bookkeeping: effective length, next counts, close detect
  always_comb begin
    eff_len  = (cfg_win_len == '0) ? {{(CW-1){1'b0}}, 1'b1} : cfg_win_len;
    win_next = {1'b0, win_cnt} + {{CW{1'b0}}, 1'b1};
    mag_next = mag_cnt + {{(CW-1){1'b0}}, hit};
    // ">=" so a length shortened below the running count closes at once
    close    = cfg_en && (state == S_RUN) && in_valid &&
               (win_next >= {1'b0, eff_len});
  end

  // dead-band comparison, one bit wider so target+hyst cannot wrap
  always_comb begin
    upper   = {1'b0, cfg_target} + {1'b0, cfg_hyst};
    lower   = {1'b0, cfg_target} - {1'b0, cfg_hyst};
    inc_req = ({1'b0, mag_cnt_last} > upper);
    dec_req = (cfg_hyst < cfg_target) && ({1'b0, mag_cnt_last} < lower);
  end

  // next-state logic; cfg_en low forces IDLE from any state
  always_comb begin
    state_nxt = state;
    if (!cfg_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_RUN;
        S_RUN:   state_nxt = close ? S_UPD : S_RUN;
        S_UPD:   state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // window and hit counters; the UPDATE-cycle sample opens the next window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_cnt <= '0;
      mag_cnt <= '0;
    end else if (!cfg_en || state == S_IDLE) begin
      win_cnt <= '0;
      mag_cnt <= '0;
    end else if (state == S_RUN) begin
      if (close) begin
        win_cnt <= '0;
        mag_cnt <= '0;
      end else if (in_valid) begin
        win_cnt <= win_next[CW-1:0];
        mag_cnt <= mag_next;
      end
    end else begin
      if (in_valid) begin
        win_cnt <= {{(CW-1){1'b0}}, 1'b1};
        mag_cnt <= {{(CW-1){1'b0}}, hit};
      end else begin
        win_cnt <= '0;
        mag_cnt <= '0;
      end
    end
  end

  // hit count of the last completed window; kept across aborts
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mag_cnt_last <= '0;
    end else if (close) begin
      mag_cnt_last <= mag_next;
    end
  end

  // threshold register: loaded in IDLE, saturating step in UPDATE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      th_reg <= '0;
    end else if (state == S_IDLE) begin
      th_reg <= cfg_th_init;
    end else if (state == S_UPD) begin
      if (inc_req) begin
        if (th_reg != th_max) begin
          th_reg <= th_reg + {{(TW-1){1'b0}}, 1'b1};
        end
      end else if (dec_req) begin
        if (th_reg > {{(TW-1){1'b0}}, 1'b1}) begin
          th_reg <= th_reg - {{(TW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // registered quantiser outputs; sig/mag hold while in_valid is low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_sig   <= 1'b0;
      out_mag   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_sig <= ~in_data[DW-1];
        out_mag <= hit;
      end
    end
  end

endmodule

// File: tb/tb_sigmag_agc.sv
// Directed bench for sigmag_agc: per-sample and per-window scoreboards.
module tb_sigmag_agc;
  localparam int DW = 12;
  localparam int TW = DW - 1;
  localparam int CW = 16;

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          cfg_en;
  logic [CW-1:0] cfg_win_len;
  logic [CW-1:0] cfg_target;
  logic [CW-1:0] cfg_hyst;
  logic [TW-1:0] cfg_th_init;
  logic          out_valid;
  logic          out_sig;
  logic          out_mag;
  logic [TW-1:0] th;
  logic          win_done;
  logic [CW-1:0] mag_cnt_last;

  sigmag_agc #(.DW(DW), .TW(TW), .CW(CW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .cfg_en       (cfg_en),
    .cfg_win_len  (cfg_win_len),
    .cfg_target   (cfg_target),
    .cfg_hyst     (cfg_hyst),
    .cfg_th_init  (cfg_th_init),
    .out_valid    (out_valid),
    .out_sig      (out_sig),
    .out_mag      (out_mag),
    .th           (th),
    .win_done     (win_done),
    .mag_cnt_last (mag_cnt_last)
  );

  typedef struct packed {logic sig; logic mag;} samp_t;
  typedef struct packed {logic [CW-1:0] mcl; logic [TW-1:0] th_new;} win_t;

  samp_t sq[$];
  win_t  wq[$];

  int errors = 0;
  int checks = 0;
  logic [TW-1:0] th_model;
  logic [TW-1:0] pend_th;
  logic upd_pending;
  logic last_sig;
  logic last_mag;
  int cyc_n;
  int last_wd;
  bit chk_period;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_mag(logic [DW-1:0] d, logic [TW-1:0] t);
    int a;
    a = int'($signed(d));
    if (a < 0) a = -a;
    if (a > (1 << (DW - 1)) - 1) a = (1 << (DW - 1)) - 1;
    return (a >= int'(t));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive a sample, score the quantiser, catch window closes
  task automatic cyc(input logic v, input logic [DW-1:0] d);
    samp_t e;
    samp_t o;
    win_t  w;
    in_valid = v;
    in_data  = d;
    if (v) begin
      e.sig = ~d[DW-1];
      e.mag = exp_mag(d, th_model);
      sq.push_back(e);
    end
    if (upd_pending) begin
      th_model    = pend_th;
      upd_pending = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    chk("out_valid", 32'(out_valid), 32'(v));
    if (v) begin
      o = sq.pop_front();
      chk("out_sig", 32'(out_sig), 32'(o.sig));
      chk("out_mag", 32'(out_mag), 32'(o.mag));
      last_sig = o.sig;
      last_mag = o.mag;
    end else begin
      chk("hold_sig", 32'(out_sig), 32'(last_sig));
      chk("hold_mag", 32'(out_mag), 32'(last_mag));
    end
    chk("th", 32'(th), 32'(th_model));
    if (win_done) begin
      chk("win_done_due", 32'(win_done), 32'(wq.size() != 0));
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("mag_cnt_last", 32'(mag_cnt_last), 32'(w.mcl));
        pend_th     = w.th_new;
        upd_pending = 1'b1;
      end
      if (chk_period && last_wd != 0) chk("win_period", 32'(cyc_n - last_wd), 32'd4);
      last_wd = cyc_n;
    end
  endtask

  task automatic expect_win(input int mcl, input int thn);
    win_t w;
    w.mcl    = CW'(mcl);
    w.th_new = TW'(thn);
    wq.push_back(w);
  endtask

  task automatic start(input int len, input int tgt, input int hy, input int thi);
    cfg_win_len = CW'(len);
    cfg_target  = CW'(tgt);
    cfg_hyst    = CW'(hy);
    cfg_th_init = TW'(thi);
    cfg_en      = 1'b1;
    th_model    = TW'(thi);
    cyc(1'b0, '0);
  endtask

  task automatic go_idle();
    cfg_en      = 1'b0;
    in_valid    = 1'b0;
    upd_pending = 1'b0;
    @(posedge clk);
    #1;
    cyc_n++;
    th_model = cfg_th_init;
    chk("idle_th", 32'(th), 32'(th_model));
    chk("idle_win_done", 32'(win_done), 32'd0);
  endtask

  task automatic drained(input string tag);
    chk(tag, 32'(wq.size()), 32'd0);
  endtask

  initial begin
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    cfg_en      = 1'b0;
    cfg_win_len = 16'd4;
    cfg_target  = '0;
    cfg_hyst    = '0;
    cfg_th_init = 11'd100;
    upd_pending = 1'b0;
    pend_th     = '0;
    last_sig    = 1'b0;
    last_mag    = 1'b0;
    cyc_n       = 0;
    last_wd     = 0;
    chk_period  = 1'b0;

    // reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sig", 32'(out_sig), 32'd0);
    chk("rst_out_mag", 32'(out_mag), 32'd0);
    chk("rst_win_done", 32'(win_done), 32'd0);
    chk("rst_mcl", 32'(mag_cnt_last), 32'd0);
    chk("rst_th", 32'(th), 32'd100);
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    th_model = 11'd100;

    // quantiser in IDLE with th = 100
    cyc(1'b1, 12'd100);
    chk("q100", {30'd0, out_sig, out_mag}, 32'b11);
    cyc(1'b1, 12'd99);
    chk("q99", {30'd0, out_sig, out_mag}, 32'b10);
    cyc(1'b1, 12'hF9C);
    chk("qm100", {30'd0, out_sig, out_mag}, 32'b01);
    cyc(1'b1, 12'h800);
    chk("qm2048", {30'd0, out_sig, out_mag}, 32'b01);
    cyc(1'b1, 12'd0);
    chk("q0", {30'd0, out_sig, out_mag}, 32'b10);
    cyc(1'b0, 12'd555);
    cfg_th_init = 11'd2047;
    th_model    = 11'd2047;
    cyc(1'b1, 12'h800);
    cyc(1'b1, 12'h801);
    cyc(1'b1, 12'h7FF);

    // increase: every window full of hits
    chk_period = 1'b1;
    last_wd    = 0;
    start(4, 1, 0, 10);
    expect_win(4, 11);
    expect_win(4, 12);
    expect_win(4, 13);
    for (int i = 0; i < 12; i++) cyc(1'b1, 12'd500);
    cyc(1'b0, '0);
    drained("inc_windows");
    chk_period = 1'b0;
    go_idle();

    // decrease to the floor of 1
    start(4, 2, 0, 2);
    expect_win(0, 1);
    expect_win(0, 1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 12'd0);
    cyc(1'b0, '0);
    drained("floor_windows");
    go_idle();

    // dead band target=2 hyst=1: 1,2,3 hold, 4 raises, 0 lowers
    start(4, 2, 1, 10);
    expect_win(1, 10);
    expect_win(2, 10);
    expect_win(3, 10);
    expect_win(4, 11);
    expect_win(0, 10);
    for (int g = 1; g <= 5; g++) begin
      for (int i = 0; i < 4; i++) begin
        if (i < (g % 5)) cyc(1'b1, (i % 2 == 1) ? 12'hE0C : 12'd500);
        else cyc(1'b1, 12'd3);
      end
      cyc(1'b0, '0);
      cyc(1'b0, '0);
    end
    drained("band_windows");
    go_idle();

    // shortened window, hyst >= target, target+hyst past CW bits
    start(8, 10, 0, 20);
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'd500);
    cfg_win_len = 16'd3;
    expect_win(6, 19);
    cyc(1'b1, 12'd500);
    cyc(1'b0, '0);
    cfg_win_len = 16'd4;
    cfg_hyst    = 16'd12;
    expect_win(0, 19);
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'd3);
    cyc(1'b0, '0);
    cfg_target = 16'hFFFF;
    cfg_hyst   = 16'd1;
    expect_win(4, 18);
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'd500);
    cyc(1'b0, '0);
    drained("cfg_windows");
    go_idle();

    // continuity across UPDATE, then abort mid-window
    chk_period = 1'b1;
    last_wd    = 0;
    start(4, 5, 0, 50);
    expect_win(4, 49);
    expect_win(4, 48);
    expect_win(4, 47);
    for (int i = 0; i < 12; i++) cyc(1'b1, 12'd60);
    cyc(1'b0, '0);
    drained("cont_windows");
    chk_period = 1'b0;
    cyc(1'b1, 12'd60);
    cyc(1'b1, 12'd60);
    go_idle();
    chk("abort_mcl_kept", 32'(mag_cnt_last), 32'd4);
    start(4, 4, 0, 50);
    expect_win(1, 49);
    cyc(1'b1, 12'd60);
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'd10);
    cyc(1'b0, '0);
    drained("restart_windows");
    go_idle();

    // asynchronous reset mid-window with th = 37
    start(2, 1, 0, 35);
    expect_win(2, 36);
    expect_win(2, 37);
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'd500);
    drained("pre_reset_windows");
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_sig", 32'(out_sig), 32'd0);
    chk("arst_out_mag", 32'(out_mag), 32'd0);
    chk("arst_win_done", 32'(win_done), 32'd0);
    chk("arst_mcl", 32'(mag_cnt_last), 32'd0);
    chk("arst_th", 32'(th), 32'd35);
    cfg_en   = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc_n++;
    resetn      = 1'b1;
    upd_pending = 1'b0;
    th_model    = cfg_th_init;
    last_sig    = 1'b0;
    last_mag    = 1'b0;
    cyc(1'b0, '0);
    chk("post_rst_win_done", 32'(win_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
